// File: rtl/alu_sequencer_if.sv
// Instruction, ALU-side and status/debug signals of the ALU issue/writeback stage.
// ALUSEQ_COND_EXEC_EN adds in_cond (to the stage) and skipped (from the stage).
interface alu_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_rd;
  logic [3:0]  in_ra;
  logic [3:0]  in_rb;
  logic        in_imm_en;
  logic [31:0] in_imm;
`ifdef ALUSEQ_COND_EXEC_EN
  logic [1:0]  in_cond;
  logic        skipped;
`endif
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_c;
  logic        alu_zero;
  logic        alu_neg;
  logic        done;
  logic [31:0] wb_data;
  logic        flag_z;
  logic        flag_n;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport slave (
`ifdef ALUSEQ_COND_EXEC_EN
    input  in_cond,
    output skipped,
`endif
    input  in_valid, in_op, in_rd, in_ra, in_rb, in_imm_en, in_imm,
    input  alu_c, alu_zero, alu_neg, dbg_addr,
    output in_ready, alu_a, alu_b, alu_op, done, wb_data, flag_z, flag_n, dbg_data
  );

  modport master (
`ifdef ALUSEQ_COND_EXEC_EN
    output in_cond,
    input  skipped,
`endif
    output in_valid, in_op, in_rd, in_ra, in_rb, in_imm_en, in_imm,
    output alu_c, alu_zero, alu_neg, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_op, done, wb_data, flag_z, flag_n, dbg_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// Issue/writeback stage around an external 32-bit ALU with a 16x32 register file and Z/N flags;
// optional ALUSEQ_COND_EXEC_EN adds condition-gated commit. Latency: 3 cycles (IDLE->EXEC->WB).
// Backpressure: in_ready is high only in IDLE; requests offered in EXEC/WB are ignored and must be held.
module alu_sequencer #(
  parameter bit ZERO_R0  = 1'b1,
  parameter bit CMP_NOWB = 1'b1
) (
  input logic           clk,
  input logic           resetn,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] rf_q [16];
  logic [31:0] alu_a_q, alu_b_q, wb_data_q;
  logic [3:0]  alu_op_q, rd_q;
  logic        wr_en_q, flag_en_q;
  logic        z_q, n_q;
  logic        flag_z_q, flag_n_q;
`ifdef ALUSEQ_COND_EXEC_EN
  logic        skip_q;
`endif

  logic        accept;
  logic [31:0] src_a, src_b;
  logic        op_defined, op_nowb, cond_ok;
  logic        wr_en_d, flag_en_d;

  assign src_a = (ZERO_R0 && bus.in_ra == 4'd0) ? 32'd0 : rf_q[bus.in_ra];
  assign src_b = (ZERO_R0 && bus.in_rb == 4'd0) ? 32'd0 : rf_q[bus.in_rb];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commit class is decided at accept so WB needs only the latched enables.
  always_comb begin
    op_defined = !(bus.in_op inside {4'd2, 4'd3, 4'd10, 4'd11});
    op_nowb    = CMP_NOWB && (bus.in_op == 4'd8 || bus.in_op == 4'd9);
`ifdef ALUSEQ_COND_EXEC_EN
    case (bus.in_cond)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = flag_z_q;
      2'b10:   cond_ok = flag_n_q;
      default: cond_ok = !flag_z_q;
    endcase
`else
    cond_ok = 1'b1;
`endif
    flag_en_d = op_defined && cond_ok;
    wr_en_d   = flag_en_d && !op_nowb && !(ZERO_R0 && bus.in_rd == 4'd0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      flag_en_q <= 1'b0;
      wb_data_q <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
`ifdef ALUSEQ_COND_EXEC_EN
      skip_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        alu_a_q   <= src_a;
        alu_b_q   <= bus.in_imm_en ? bus.in_imm : src_b;
        alu_op_q  <= bus.in_op;
        rd_q      <= bus.in_rd;
        wr_en_q   <= wr_en_d;
        flag_en_q <= flag_en_d;
`ifdef ALUSEQ_COND_EXEC_EN
        skip_q    <= !cond_ok;
`endif
      end
      if (state_q == EXEC) begin
        wb_data_q <= bus.alu_c;
        z_q       <= bus.alu_zero;
        n_q       <= bus.alu_neg;
      end
      if (state_q == WB) begin
        if (wr_en_q) rf_q[rd_q] <= wb_data_q;
        if (flag_en_q) begin
          flag_z_q <= z_q;
          flag_n_q <= n_q;
        end
      end
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.done     = (state_q == WB);
  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.flag_z   = flag_z_q;
  assign bus.flag_n   = flag_n_q;
  assign bus.dbg_data = (ZERO_R0 && bus.dbg_addr == 4'd0) ? 32'd0 : rf_q[bus.dbg_addr];
`ifdef ALUSEQ_COND_EXEC_EN
  assign bus.skipped  = (state_q == WB) && skip_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU on the ALU port, directed scenarios, then random instructions
// scored against an array-based register-file/flag model.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  alu_sequencer_if bus();

  alu_sequencer #(.ZERO_R0(1'b1), .CMP_NOWB(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] m_rf [16];
  logic        m_z, m_n;

  // CMP is a signed three-way compare: -1 / 0 / +1.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return ~a;
      4'd8:  return ($signed(a) < $signed(b)) ? 32'hFFFF_FFFF : ((a == b) ? 32'd0 : 32'd1);
      4'd9:  return a & b;
      4'd12: return a << b[4:0];
      4'd13: return a >> b[4:0];
      4'd14: return p[31:0];
      4'd15: return p[63:32];
      default: return 32'd0;
    endcase
  endfunction

  assign bus.alu_c    = alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);
  assign bus.alu_zero = (bus.alu_c == 32'd0);
  assign bus.alu_neg  = bus.alu_c[31];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic dbg_read(input logic [3:0] a, output logic [31:0] d);
    bus.dbg_addr = a;
    #1;
    d = bus.dbg_data;
  endtask

  task automatic drive_accept(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                              input logic [3:0] rb, input logic imm_en, input logic [31:0] imm,
                              input logic [1:0] cond);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("ready_wait", 32'd0, 32'd1);
    bus.in_op     = op;
    bus.in_rd     = rd;
    bus.in_ra     = ra;
    bus.in_rb     = rb;
    bus.in_imm_en = imm_en;
    bus.in_imm    = imm;
`ifdef ALUSEQ_COND_EXEC_EN
    bus.in_cond   = cond;
`endif
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                           input logic [3:0] rb, input logic imm_en, input logic [31:0] imm,
                           input logic [1:0] cond, input bit hold_vld);
    logic [31:0] a, b, c, d;
    logic        cond_ok, defined, fl, wr;
    int          cyc, pulses;
    a = (ra == 4'd0) ? 32'd0 : m_rf[ra];
    b = imm_en ? imm : ((rb == 4'd0) ? 32'd0 : m_rf[rb]);
    c = alu_ref(op, a, b);
`ifdef ALUSEQ_COND_EXEC_EN
    case (cond)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = m_z;
      2'b10:   cond_ok = m_n;
      default: cond_ok = !m_z;
    endcase
`else
    cond_ok = 1'b1;
`endif
    defined = !(op inside {4'd2, 4'd3, 4'd10, 4'd11});
    fl = defined && cond_ok;
    wr = fl && op != 4'd8 && op != 4'd9 && rd != 4'd0;
    drive_accept(op, rd, ra, rb, imm_en, imm, cond);
    if (!hold_vld) bus.in_valid = 1'b0;
    check("exec_no_done", bus.done, 1'b0);
    cyc = 1;
    while (!bus.done && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", cyc, 2);
    check("wb_data", bus.wb_data, c);
    check("wb_not_ready", bus.in_ready, 1'b0);
`ifdef ALUSEQ_COND_EXEC_EN
    check("skipped", bus.skipped, !cond_ok);
`endif
    if (fl) begin
      m_z = (c == 32'd0);
      m_n = c[31];
    end
    if (wr) m_rf[rd] = c;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("done_clear", bus.done, 1'b0);
    check("flag_z", bus.flag_z, m_z);
    check("flag_n", bus.flag_n, m_n);
    dbg_read(rd, d);
    check("rd_value", d, m_rf[rd]);
    if (hold_vld) begin
      pulses = 0;
      repeat (6) begin
        @(posedge clk);
        #1;
        if (bus.done) pulses++;
      end
      check("one_accept", pulses, 0);
    end
  endtask

  // Aborts an ADD r3 = 7 by reset in EXEC (in_wb=0) or in WB (in_wb=1).
  task automatic abort_test(input bit in_wb);
    logic [31:0] d;
    int pulses;
    drive_accept(4'd0, 4'd3, 4'd0, 4'd0, 1'b1, 32'd7, 2'b00);
    bus.in_valid = 1'b0;
    if (in_wb) begin
      @(posedge clk);
      #1;
    end
    #1 resetn = 1'b0;
    #1;
    check("abort_done", bus.done, 1'b0);
    check("abort_fz", bus.flag_z, 1'b0);
    check("abort_fn", bus.flag_n, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    dbg_read(4'd3, d);
    check("abort_r3", d, 32'd0);
  endtask

  logic [3:0] op_tab [14] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                              4'd12, 4'd13, 4'd14, 4'd15, 4'd10, 4'd2};

  initial begin
    logic [31:0] d, imm;
    logic        sz, sn;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rd     = '0;
    bus.in_ra     = '0;
    bus.in_rb     = '0;
    bus.in_imm_en = 1'b0;
    bus.in_imm    = '0;
    bus.dbg_addr  = '0;
`ifdef ALUSEQ_COND_EXEC_EN
    bus.in_cond   = 2'b00;
`endif
    for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
    m_z = 1'b0;
    m_n = 1'b0;

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rst_ready", bus.in_ready, 1'b1);
    check("rst_done", bus.done, 1'b0);
    check("rst_fz", bus.flag_z, 1'b0);
    check("rst_fn", bus.flag_n, 1'b0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_alu_op", bus.alu_op, 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    for (int i = 0; i < 16; i++) begin
      dbg_read(i[3:0], d);
      check("rst_reg", d, 32'd0);
    end

    abort_test(1'b1);
    abort_test(1'b0);

    run_instr(4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 32'd5, 2'b00, 1'b0);
    run_instr(4'd1, 4'd2, 4'd1, 4'd0, 1'b1, 32'd5, 2'b00, 1'b0);
    dbg_read(4'd1, d);
    check("t2_r1", d, 32'd5);
    dbg_read(4'd2, d);
    check("t2_r2", d, 32'd0);
    check("t2_fz", bus.flag_z, 1'b1);
    check("t2_fn", bus.flag_n, 1'b0);

    run_instr(4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 32'd3, 2'b00, 1'b0);
    run_instr(4'd0, 4'd2, 4'd0, 4'd0, 1'b1, 32'd7, 2'b00, 1'b0);
    run_instr(4'd8, 4'd4, 4'd1, 4'd2, 1'b0, 32'd0, 2'b00, 1'b0);
    check("t3_fn", bus.flag_n, 1'b1);
    dbg_read(4'd4, d);
    check("t3_r4", d, 32'd0);

    run_instr(4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 32'd1, 2'b00, 1'b0);
    run_instr(4'd12, 4'd5, 4'd1, 4'd0, 1'b1, 32'd31, 2'b00, 1'b0);
    dbg_read(4'd5, d);
    check("t4_shl", d, 32'h8000_0000);
    check("t4_fn", bus.flag_n, 1'b1);
    run_instr(4'd0, 4'd7, 4'd0, 4'd0, 1'b1, 32'hFFFF_FFFF, 2'b00, 1'b0);
    run_instr(4'd15, 4'd6, 4'd7, 4'd7, 1'b0, 32'd0, 2'b00, 1'b0);
    dbg_read(4'd6, d);
    check("t4_mulhi", d, 32'hFFFF_FFFE);

    run_instr(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 32'd9, 2'b00, 1'b0);
    dbg_read(4'd0, d);
    check("t5_r0", d, 32'd0);
    sz = bus.flag_z;
    sn = bus.flag_n;
    run_instr(4'd10, 4'd9, 4'd1, 4'd2, 1'b0, 32'd0, 2'b00, 1'b0);
    check("t5_nop_fz", bus.flag_z, sz);
    check("t5_nop_fn", bus.flag_n, sn);
    run_instr(4'd0, 4'd8, 4'd0, 4'd0, 1'b1, 32'h1234, 2'b00, 1'b1);

`ifdef ALUSEQ_COND_EXEC_EN
    run_instr(4'd0, 4'd2, 4'd0, 4'd0, 1'b1, 32'd1, 2'b00, 1'b0);
    run_instr(4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 32'h55, 2'b01, 1'b0);
    dbg_read(4'd1, d);
    check("t6_skip_r1", d, 32'd1);
    run_instr(4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 32'h55, 2'b11, 1'b0);
    dbg_read(4'd1, d);
    check("t6_exec_r1", d, 32'h55);
`endif

    repeat (150) begin
      imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      run_instr(op_tab[$urandom_range(0, 13)], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), imm,
                2'($urandom_range(0, 3)), 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      dbg_read(i[3:0], d);
      check("final_reg", d, m_rf[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
